// File: rtl/sram_frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_frame_reader_if
//  Description : Bundle of the frame-reader control, pixel stream and async
//                SRAM control/address signals.
//                master : the frame reader (drives status, stream, SRAM ctl)
//                slave  : the system side (drives start, pix_ready; SRAM model)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_frame_reader_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [19:0] sram_addr;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        ub_n;
    logic        lb_n;

    modport master (
        input  start,
        output busy,
        output done,
        output pix_data,
        output pix_valid,
        input  pix_ready,
        output sram_addr,
        output ce_n,
        output oe_n,
        output we_n,
        output ub_n,
        output lb_n
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        input  sram_addr,
        input  ce_n,
        input  oe_n,
        input  we_n,
        input  ub_n,
        input  lb_n
    );
endinterface
`default_nettype wire

// File: rtl/sram_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sram_frame_reader
//  Description : Reads NUM_WORDS consecutive 16-bit words from an async SRAM
//                starting at BASE_ADDR on each start pulse, and streams them
//                in address order through a 2-entry valid/ready FIFO.
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous active-high reset
//                bus      - start/busy/done, pixel stream, SRAM addr/ctl
//                sram_dq  - SRAM data bus, only ever read (held high-Z)
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_frame_reader #(
    parameter logic [19:0] BASE_ADDR = 20'h00000,
    parameter logic [20:0] NUM_WORDS = 21'd1048576,
    parameter int unsigned READ_WAIT = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    sram_frame_reader_if.master  bus,
    inout  wire       [15:0]     sram_dq
);

    localparam int unsigned         WAIT_W    = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_INIT = WAIT_W'(READ_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [19:0]         addr_q, addr_d;            // next address to issue
    logic [19:0]         sram_addr_q, sram_addr_d;  // address presented to SRAM
    logic [20:0]         word_cnt_q, word_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                oe_n_q;
    logic                busy_q;
    logic                done_q;

    logic [15:0]         fifo_q [2];
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic [1:0]          count_q, count_d;
    logic                push;
    logic                pop;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        push        = (state_q == S_CAPTURE);
        pop         = (count_q != 2'd0) && bus.pix_ready;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};

        state_d     = state_q;
        addr_d      = addr_q;
        sram_addr_d = sram_addr_q;
        word_cnt_d  = word_cnt_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_ISSUE;
                    addr_d      = BASE_ADDR;
                    sram_addr_d = BASE_ADDR;
                    word_cnt_d  = '0;
                end
            end
            S_ISSUE: begin
                state_d    = S_WAIT;
                wait_cnt_d = WAIT_INIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                word_cnt_d = word_cnt_q + 21'd1;
                addr_d     = addr_q + 20'd1;        // wraps at 2^20
                if (word_cnt_d == NUM_WORDS) begin
                    state_d = S_DRAIN;
                end else if (count_d != 2'd2) begin
                    // The freed slot is reserved for the single in-flight read.
                    state_d     = S_ISSUE;
                    sram_addr_d = addr_d;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (count_q != 2'd2) begin
                    state_d     = S_ISSUE;
                    sram_addr_d = addr_q;
                end
            end
            S_DRAIN: begin
                if (count_q == 2'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sram_addr_q <= '0;
            word_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            oe_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sram_addr_q <= sram_addr_d;
            word_cnt_q  <= word_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            // oe_n stays low across ISSUE/WAIT/CAPTURE of back-to-back reads.
            oe_n_q      <= !((state_d == S_ISSUE) || (state_d == S_WAIT) ||
                             (state_d == S_CAPTURE));
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_q == S_DRAIN) && (state_d == S_IDLE);
            count_q     <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= sram_dq;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pix_data  = fifo_q[rd_ptr_q];
    assign bus.pix_valid = (count_q != 2'd0);
    assign bus.sram_addr = sram_addr_q;
    assign bus.oe_n      = oe_n_q;
    assign bus.ce_n      = 1'b0;
    assign bus.we_n      = 1'b1;
    assign bus.ub_n      = 1'b0;
    assign bus.lb_n      = 1'b0;
    assign sram_dq       = 16'bz;

endmodule
`default_nettype wire

// File: tb/tb_sram_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_frame_reader
//  Description : Self-checking bench. Three readers with different parameter
//                sets share one clock/reset; a frame-level model predicts the
//                word stream, issue addresses, busy and done for each.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_frame_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  ready_v;

    wire  [2:0]  busy_w, done_w, valid_w, oe_w, ce_w, we_w, ub_w, lb_w;
    wire  [47:0] data_w;
    wire  [59:0] addr_w;

    always #5 clk = ~clk;

    // Instance 0: BASE 0, 4 words, READ_WAIT 1
    // Instance 1: BASE FFFFE, 4 words, READ_WAIT 1
    // Instance 2: BASE 0, 2 words, READ_WAIT 3
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam logic [19:0] P_BASE = (gi == 1) ? 20'hFFFFE : 20'h00000;
        localparam logic [20:0] P_NW   = (gi == 2) ? 21'd2 : 21'd4;
        localparam int unsigned P_RW   = (gi == 2) ? 3 : 1;

        sram_frame_reader_if ifc ();
        wire [15:0] dq;

        // Async SRAM model: drives addr ^ A5A5 whenever output-enabled.
        assign dq            = ifc.oe_n ? 16'bz : (ifc.sram_addr[15:0] ^ 16'hA5A5);
        assign ifc.start     = start_v[gi];
        assign ifc.pix_ready = ready_v[gi];
        assign busy_w[gi]    = ifc.busy;
        assign done_w[gi]    = ifc.done;
        assign valid_w[gi]   = ifc.pix_valid;
        assign oe_w[gi]      = ifc.oe_n;
        assign ce_w[gi]      = ifc.ce_n;
        assign we_w[gi]      = ifc.we_n;
        assign ub_w[gi]      = ifc.ub_n;
        assign lb_w[gi]      = ifc.lb_n;
        assign data_w[gi*16 +: 16] = ifc.pix_data;
        assign addr_w[gi*20 +: 20] = ifc.sram_addr;

        sram_frame_reader #(
            .BASE_ADDR (P_BASE),
            .NUM_WORDS (P_NW),
            .READ_WAIT (P_RW)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (ifc),
            .sram_dq (dq)
        );
    end

    // ------------------------------------------------------------------
    // Bookkeeping and model state
    // ------------------------------------------------------------------
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    logic        active   [3];
    int          pop_k    [3];
    int          iss_k    [3];
    int          done_due [3];
    int          words    [3];
    int          obs_done [3];

    logic [2:0]  p_start, p_ready, p_valid, p_oe;
    logic        p_rst;
    logic [15:0] p_data [3];
    logic [19:0] p_addr [3];

    logic [19:0] wrap_log [4];
    int          log_n;
    logic [19:0] wrap_exp [4];
    logic [15:0] lit_a    [4];

    function automatic logic [19:0] base_of(input int i);
        return (i == 1) ? 20'hFFFFE : 20'h00000;
    endfunction

    function automatic int nw_of(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic logic [15:0] exp_word(input int i, input int k);
        logic [19:0] a;
        a = base_of(i) + 20'(k);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the frame-level model.
    task automatic compare();
        for (int i = 0; i < 3; i++) begin
            logic        v, b, dn, oe, exp_done;
            logic [15:0] d;
            logic [19:0] a, ea;
            v  = valid_w[i];
            b  = busy_w[i];
            dn = done_w[i];
            oe = oe_w[i];
            d  = data_w[i*16 +: 16];
            a  = addr_w[i*20 +: 20];
            if (dn) obs_done[i]++;
            if (p_rst) begin
                active[i]   = 1'b0;
                pop_k[i]    = 0;
                iss_k[i]    = 0;
                done_due[i] = -1;
                chk("rst_valid", 32'(v), 32'd0);
                chk("rst_busy",  32'(b), 32'd0);
                chk("rst_done",  32'(dn), 32'd0);
                chk("rst_oe_n",  32'(oe), 32'd1);
                chk("rst_addr",  32'(a), 32'd0);
                chk("rst_data",  32'(d), 32'd0);
            end else begin
                if (p_start[i] && !active[i]) begin
                    active[i]   = 1'b1;
                    pop_k[i]    = 0;
                    iss_k[i]    = 0;
                    done_due[i] = -1;
                end
                if (p_valid[i] && p_ready[i]) begin
                    if (pop_k[i] >= nw_of(i))
                        chk("extra_word", 32'(p_data[i]), 32'hFFFF_FFFF);
                    else
                        chk("word", 32'(p_data[i]), 32'(exp_word(i, pop_k[i])));
                    pop_k[i]++;
                    words[i]++;
                    // Last pop in cycle c-1: DRAIN sees empty in c, done in c+1.
                    if (pop_k[i] == nw_of(i)) done_due[i] = cyc + 1;
                end else if (p_valid[i]) begin
                    chk("stall_valid", 32'(v), 32'd1);
                    chk("stall_data",  32'(d), 32'(p_data[i]));
                end
                exp_done = (cyc == done_due[i]);
                if (exp_done) active[i] = 1'b0;
                chk("done", 32'(dn), 32'(exp_done));
                chk("busy", 32'(b),  32'(active[i]));
                if (!active[i]) chk("idle_valid", 32'(v), 32'd0);
                if (!oe && (p_oe[i] || (a != p_addr[i]))) begin
                    if (!active[i] || iss_k[i] >= nw_of(i)) begin
                        chk("unexpected_issue", 32'(a), 32'hFFFF_FFFF);
                    end else begin
                        ea = base_of(i) + 20'(iss_k[i]);
                        chk("issue_addr", 32'(a), 32'(ea));
                    end
                    if (i == 1 && log_n < 4) begin
                        wrap_log[log_n] = a;
                        log_n++;
                    end
                    iss_k[i]++;
                end
            end
            chk("ce_n", 32'(ce_w[i]), 32'd0);
            chk("we_n", 32'(we_w[i]), 32'd1);
            chk("ub_n", 32'(ub_w[i]), 32'd0);
            chk("lb_n", 32'(lb_w[i]), 32'd0);
            p_valid[i] = v;
            p_oe[i]    = oe;
            p_data[i]  = d;
            p_addr[i]  = a;
        end
    endtask

    // Inputs set before this call are sampled at the coming edge; the
    // outputs of the following cycle are checked at its falling edge.
    task automatic cycle();
        p_start = start_v;
        p_ready = ready_v;
        p_rst   = rst;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic run_until_done(input int i, input int budget);
        int n;
        n = 0;
        while (!done_w[i] && n < budget) begin
            cycle();
            start_v = 3'b000;
            n++;
        end
        chk("done_timeout", 32'(done_w[i]), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int w0, d0;
        for (int i = 0; i < 3; i++) begin
            active[i] = 1'b0; pop_k[i] = 0; iss_k[i] = 0; done_due[i] = -1;
            words[i] = 0; obs_done[i] = 0; p_data[i] = '0; p_addr[i] = '0;
        end
        p_valid = '0; p_oe = 3'b111; p_start = '0; p_ready = '0; p_rst = 1'b1;
        log_n = 0;
        wrap_exp[0] = 20'hFFFFE; wrap_exp[1] = 20'hFFFFF;
        wrap_exp[2] = 20'h00000; wrap_exp[3] = 20'h00001;
        lit_a[0] = 16'hA5A5; lit_a[1] = 16'hA5A4; lit_a[2] = 16'hA5A7; lit_a[3] = 16'hA5A6;

        // Reset, with start held high to show it is ignored under reset
        rst = 1'b1; start_v = 3'b111; ready_v = 3'b111;
        repeat (3) cycle();
        start_v = 3'b000; rst = 1'b0;
        cycle();
        chk("reset_addr0", 32'(addr_w[19:0]), 32'd0);
        chk("reset_busy",  32'(busy_w), 32'd0);

        // Basic 4-word frame, consumer always ready; literal timeline
        start_v = 3'b001;
        for (int t = 1; t <= 16; t++) begin
            cycle();
            start_v = 3'b000;
            chk("A_busy",  32'(busy_w[0]),  32'(t <= 14));
            chk("A_done",  32'(done_w[0]),  32'(t == 15));
            chk("A_valid", 32'(valid_w[0]), 32'(t inside {4, 7, 10, 13}));
            if (t inside {1, 4, 7, 10}) begin
                chk("A_issue_oe",   32'(oe_w[0]), 32'd0);
                chk("A_issue_addr", 32'(addr_w[19:0]), 32'((t - 1) / 3));
            end
            if (t inside {4, 7, 10, 13})
                chk("A_data", 32'(data_w[15:0]), 32'(lit_a[(t - 4) / 3]));
        end

        // Backpressure: consumer stalled, reader must park in HOLD
        ready_v = 3'b110;
        w0 = words[0]; d0 = obs_done[0];
        start_v = 3'b001;
        for (int t = 1; t <= 12; t++) begin
            cycle();
            start_v = 3'b000;
        end
        chk("B_hold_oe",     32'(oe_w[0]), 32'd1);
        chk("B_hold_valid",  32'(valid_w[0]), 32'd1);
        chk("B_hold_data",   32'(data_w[15:0]), 32'h0000_A5A5);
        chk("B_issue_count", 32'(iss_k[0]), 32'd2);
        chk("B_hold_busy",   32'(busy_w[0]), 32'd1);
        ready_v = 3'b111;
        run_until_done(0, 60);
        cycle();
        chk("B_words", 32'(words[0] - w0), 32'd4);
        chk("B_dones", 32'(obs_done[0] - d0), 32'd1);

        // Address wrap at the top of the SRAM
        log_n = 0;
        start_v = 3'b010;
        run_until_done(1, 60);
        cycle();
        chk("C_issue_count", 32'(log_n), 32'd4);
        for (int k = 0; k < 4; k++)
            chk("C_wrap_addr", 32'(wrap_log[k]), 32'(wrap_exp[k]));

        // READ_WAIT = 3, two words
        start_v = 3'b100;
        for (int t = 1; t <= 10; t++) begin
            cycle();
            start_v = 3'b000;
            chk("D_valid", 32'(valid_w[2]), 32'(t == 6));
            if (t >= 1 && t <= 4) begin
                chk("D_oe_w0",   32'(oe_w[2]), 32'd0);
                chk("D_addr_w0", 32'(addr_w[59:40]), 32'd0);
            end
            if (t >= 6 && t <= 9) begin
                chk("D_oe_w1",   32'(oe_w[2]), 32'd0);
                chk("D_addr_w1", 32'(addr_w[59:40]), 32'd1);
            end
            if (t == 6) chk("D_data0", 32'(data_w[47:32]), 32'h0000_A5A5);
        end
        run_until_done(2, 40);
        cycle();

        // Reset during the WAIT of the second word
        d0 = obs_done[0];
        start_v = 3'b001;
        for (int t = 1; t <= 5; t++) begin
            cycle();
            start_v = 3'b000;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("E_valid", 32'(valid_w[0]), 32'd0);
        chk("E_busy",  32'(busy_w[0]),  32'd0);
        chk("E_oe",    32'(oe_w[0]),    32'd1);
        chk("E_addr",  32'(addr_w[19:0]), 32'd0);
        repeat (12) cycle();
        chk("E_no_done", 32'(obs_done[0] - d0), 32'd0);
        w0 = words[0];
        start_v = 3'b001;
        run_until_done(0, 60);
        cycle();
        chk("E_words", 32'(words[0] - w0), 32'd4);

        // start pulses while busy and during DRAIN are ignored
        w0 = words[0]; d0 = obs_done[0];
        start_v = 3'b001;
        for (int t = 1; t <= 24; t++) begin
            cycle();
            start_v = (t inside {5, 13, 14}) ? 3'b001 : 3'b000;
        end
        chk("F_words", 32'(words[0] - w0), 32'd4);
        chk("F_dones", 32'(obs_done[0] - d0), 32'd1);
        chk("F_idle",  32'(busy_w[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
